uart_tx_arbiter: RTL and testbench

//  Round-robin arbiter and sequencer that shares one uart_tx transmitter among

---
 rtl/uart_tx_arbiter.sv | 159 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//
// Shares one uart_tx transmitter among NREQ byte requesters. A round-robin
// choice picks one pending requester, its byte is handed to uart_tx with a
// single start pulse, and the arbiter then waits for the transmitter's done
// tick. After that it keeps the line idle for GAP_TICKS baud ticks before
// arbitrating again.
//
// Parameters:
//   NREQ       number of requesters (2..8, any value)
//   IDW        width of grant_id, 2**IDW >= NREQ
//   GAP_TICKS  s_ticks of idle line after every frame (0 = no gap)
//
// Ports:
//   clk           system clock, rising edge
//   reset         synchronous, active-high
//   s_tick        16x baud oversample tick, one clk wide
//   req_valid     requester i has a byte pending
//   req_data      byte of requester i at [8*i+7:8*i]
//   req_ready     one-hot 1-clk pulse, byte of requester i taken
//   tx_start      1-clk start pulse to uart_tx
//   tx_din        byte to uart_tx, held until the frame is done
//   tx_done_tick  end-of-stop-bit pulse from uart_tx
//   grant_id      index of the current/last granted requester
//   busy          high whenever the arbiter is not idle

module uart_tx_arbiter #(
    parameter int NREQ      = 4,
    parameter int IDW       = 2,
    parameter int GAP_TICKS = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 s_tick,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [8*NREQ-1:0]    req_data,
    output logic [NREQ-1:0]      req_ready,
    output logic                 tx_start,
    output logic [7:0]           tx_din,
    input  logic                 tx_done_tick,
    output logic [IDW-1:0]       grant_id,
    output logic                 busy
);

    // The gap counter counts up to GAP_TICKS without wrapping. With no gap
    // the counter is never used but still needs a legal width.
    localparam int CW = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;
    localparam logic [CW-1:0] GAP_LAST = CW'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_DONE,
        GAP
    } state_t;

    state_t          state;
    logic [IDW-1:0]  ptr;
    logic [CW-1:0]   gap_cnt;

    logic [NREQ-1:0] rot;
    logic            any_req;
    logic [IDW-1:0]  sel;
    logic [IDW:0]    sum;
    logic [7:0]      sel_data;
    logic [NREQ-1:0] sel_onehot;
    logic [IDW-1:0]  ptr_next;

    // Round-robin search. The request vector is rotated so that bit 0 is the
    // requester at ptr; the first set bit of the rotated vector gives the
    // offset from ptr, which is folded back into 0..NREQ-1 without a modulo
    // so that non-power-of-2 NREQ works.
    always_comb begin
        rot     = NREQ'({req_valid, req_valid} >> ptr);
        any_req = 1'b0;
        sel     = '0;
        sum     = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!any_req && rot[k]) begin
                any_req = 1'b1;
                sum     = {1'b0, ptr} + (IDW+1)'(k);
                if (sum >= (IDW+1)'(NREQ)) begin
                    sum = sum - (IDW+1)'(NREQ);
                end
                sel = sum[IDW-1:0];
            end
        end
    end

    // Byte and ready mask of the winner, plus the pointer that gives the
    // winner the lowest priority in the next round.
    always_comb begin
        sel_data   = '0;
        sel_onehot = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (sel == IDW'(i)) begin
                sel_data      = req_data[8*i +: 8];
                sel_onehot[i] = 1'b1;
            end
        end
        ptr_next = (sel == IDW'(NREQ - 1)) ? '0 : sel + IDW'(1);
    end

    // Sequencer. req_ready and tx_start default low every cycle so they are
    // single-cycle pulses. In WAIT_DONE the done tick has priority over a
    // coincident s_tick: the counter is cleared rather than advanced.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            ptr       <= '0;
            gap_cnt   <= '0;
            req_ready <= '0;
            tx_start  <= 1'b0;
            tx_din    <= 8'h00;
            grant_id  <= '0;
            busy      <= 1'b0;
        end else begin
            req_ready <= '0;
            tx_start  <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        tx_din    <= sel_data;
                        grant_id  <= sel;
                        req_ready <= sel_onehot;
                        tx_start  <= 1'b1;
                        ptr       <= ptr_next;
                        busy      <= 1'b1;
                        state     <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (tx_done_tick) begin
                        gap_cnt <= '0;
                        if (GAP_TICKS == 0) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state <= GAP;
                        end
                    end
                end
                GAP: begin
                    if (s_tick) begin
                        gap_cnt <= gap_cnt + CW'(1);
                        if (gap_cnt == GAP_LAST) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter
//
// Drives two arbiters (GAP_TICKS=16 and GAP_TICKS=0) from the same requester
// and transmitter stimulus and compares every output of both on every cycle
// against a transaction-level reference model of the arbitration rules.
// Stimulus runs in three phases: a single requester holding 8'hA5, all four
// requesters continuously valid, then fully random traffic with spurious done
// ticks, dropped requests and mid-frame resets.

module tb_uart_tx_arbiter;

    localparam int NREQ   = 4;
    localparam int IDW    = 2;
    localparam int NCYCLE = 6000;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 s_tick;
    logic                 tx_done_tick;
    logic [NREQ-1:0]      req_valid;
    logic [8*NREQ-1:0]    req_data;

    logic [NREQ-1:0]      ready_a, ready_b;
    logic                 start_a, start_b;
    logic [7:0]           din_a, din_b;
    logic [IDW-1:0]       gid_a, gid_b;
    logic                 busy_a, busy_b;

    // Reference model state: is a frame outstanding, how many gap ticks are
    // still owed, and which requester is searched first next time.
    int                   gap_cfg [2] = '{16, 0};
    bit                   m_send  [2];
    int                   m_gap   [2];
    int                   m_ptr   [2];

    // Expected registered outputs after the coming clock edge.
    logic                 e_start [2];
    logic [NREQ-1:0]      e_ready [2];
    logic [7:0]           e_din   [2];
    int                   e_gid   [2];
    logic                 e_busy  [2];

    // Requester and transmitter behaviour.
    logic [NREQ-1:0]      pend;
    logic [7:0]           bytes [NREQ];
    int                   done_cd;

    int                   n_vec  = 0;
    int                   n_miss = 0;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.NREQ(NREQ), .IDW(IDW), .GAP_TICKS(16)) dut_gap (
        .clk          (clk),
        .reset        (reset),
        .s_tick       (s_tick),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (ready_a),
        .tx_start     (start_a),
        .tx_din       (din_a),
        .tx_done_tick (tx_done_tick),
        .grant_id     (gid_a),
        .busy         (busy_a)
    );

    uart_tx_arbiter #(.NREQ(NREQ), .IDW(IDW), .GAP_TICKS(0)) dut_nogap (
        .clk          (clk),
        .reset        (reset),
        .s_tick       (s_tick),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (ready_b),
        .tx_start     (start_b),
        .tx_din       (din_b),
        .tx_done_tick (tx_done_tick),
        .grant_id     (gid_b),
        .busy         (busy_b)
    );

    // Single comparison point: counts every comparison and reports misses.
    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("[TB] FAIL %s at %0t: got %0h, expected %0h", tag, $time, act, exp);
        end
    endtask

    // Compares all outputs of both instances with the model's predictions.
    task automatic checkAll();
        checkOutput("gap.tx_start",   32'(start_a), 32'(e_start[0]));
        checkOutput("gap.req_ready",  32'(ready_a), 32'(e_ready[0]));
        checkOutput("gap.tx_din",     32'(din_a),   32'(e_din[0]));
        checkOutput("gap.grant_id",   32'(gid_a),   32'(e_gid[0]));
        checkOutput("gap.busy",       32'(busy_a),  32'(e_busy[0]));
        checkOutput("nogap.tx_start", 32'(start_b), 32'(e_start[1]));
        checkOutput("nogap.req_ready",32'(ready_b), 32'(e_ready[1]));
        checkOutput("nogap.tx_din",   32'(din_b),   32'(e_din[1]));
        checkOutput("nogap.grant_id", 32'(gid_b),   32'(e_gid[1]));
        checkOutput("nogap.busy",     32'(busy_b),  32'(e_busy[1]));
    endtask

    // Reference model, advanced once per clock with the inputs that the DUT
    // will sample on the coming edge.
    task automatic stepModel();
        int  w;
        bool_found: begin end
        for (int d = 0; d < 2; d++) begin
            bit found;
            e_start[d] = 1'b0;
            e_ready[d] = '0;
            if (reset) begin
                m_send[d] = 1'b0;
                m_gap[d]  = 0;
                m_ptr[d]  = 0;
                e_din[d]  = 8'h00;
                e_gid[d]  = 0;
            end else if (m_send[d]) begin
                if (tx_done_tick) begin
                    m_send[d] = 1'b0;
                    m_gap[d]  = gap_cfg[d];
                end
            end else if (m_gap[d] > 0) begin
                if (s_tick) m_gap[d] = m_gap[d] - 1;
            end else begin
                found = 1'b0;
                for (int k = 0; k < NREQ; k++) begin
                    w = (m_ptr[d] + k) % NREQ;
                    if (!found && req_valid[w]) begin
                        found      = 1'b1;
                        e_start[d] = 1'b1;
                        e_ready[d] = NREQ'(1) << w;
                        e_din[d]   = req_data[8*w +: 8];
                        e_gid[d]   = w;
                        m_ptr[d]   = (w + 1) % NREQ;
                        m_send[d]  = 1'b1;
                    end
                end
            end
            e_busy[d] = m_send[d] || (m_gap[d] > 0);
        end
    endtask

    // Requesters react to the grant seen on the previous edge; the
    // transmitter returns a done tick a random number of cycles after each
    // start of the GAP_TICKS=16 instance.
    task automatic applyStimulus(input int cyc);
        int mode;
        mode  = (cyc < 400) ? 0 : (cyc < 1500) ? 1 : 2;
        reset = (cyc < 3) || (mode == 2 && $urandom_range(0, 399) == 0);

        for (int i = 0; i < NREQ; i++) begin
            if (e_ready[0][i]) begin
                if (mode != 2 || $urandom_range(0, 1) == 1) begin
                    bytes[i] = 8'($urandom);
                    pend[i]  = 1'b1;
                end else begin
                    pend[i]  = 1'b0;
                end
            end else if (mode == 2) begin
                if (!pend[i] && $urandom_range(0, 9) == 0) begin
                    pend[i]  = 1'b1;
                    bytes[i] = 8'($urandom);
                end else if (pend[i] && $urandom_range(0, 79) == 0) begin
                    pend[i]  = 1'b0;
                end
            end
        end
        if (mode == 0) begin
            pend     = 4'b0010;
            bytes[1] = 8'hA5;
        end else if (mode == 1) begin
            pend     = 4'b1111;
        end
        req_valid = pend;
        req_data  = {bytes[3], bytes[2], bytes[1], bytes[0]};

        s_tick       = ($urandom_range(0, 2) == 0);
        tx_done_tick = 1'b0;
        if (reset) begin
            done_cd = 0;
        end else if (e_start[0]) begin
            done_cd = $urandom_range(4, 40);
        end else if (done_cd > 0) begin
            done_cd--;
            if (done_cd == 0) tx_done_tick = 1'b1;
        end
        if (mode == 2 && $urandom_range(0, 59) == 0) tx_done_tick = 1'b1;
    endtask

    // Main sequence: drive, predict, clock, then check on the falling edge.
    initial begin
        reset        = 1'b1;
        s_tick       = 1'b0;
        tx_done_tick = 1'b0;
        req_valid    = '0;
        req_data     = '0;
        pend         = '0;
        done_cd      = 0;
        for (int i = 0; i < NREQ; i++) bytes[i] = 8'h00;
        for (int d = 0; d < 2; d++) begin
            m_send[d]  = 1'b0;
            m_gap[d]   = 0;
            m_ptr[d]   = 0;
            e_start[d] = 1'b0;
            e_ready[d] = '0;
            e_din[d]   = 8'h00;
            e_gid[d]   = 0;
            e_busy[d]  = 1'b0;
        end

        for (int cyc = 0; cyc < NCYCLE; cyc++) begin
            applyStimulus(cyc);
            stepModel();
            @(posedge clk);
            @(negedge clk);
            checkAll();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
